// File: rtl/queue_access_arbiter.sv
// Arbitrates two writers and one reader onto a single Queue, sequencing one op every 4 cycles.
// Define QUEUE_ARB_FIXED_PRIO_EN for fixed priority W0 > W1 > R instead of round-robin.
module queue_access_arbiter #(
    parameter int unsigned DATA_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req0,
    input  logic [DATA_W-1:0] i_wr_data0,
    output logic              o_wr_ack0,
    input  logic              i_wr_req1,
    input  logic [DATA_W-1:0] i_wr_data1,
    output logic              o_wr_ack1,
    input  logic              i_rd_req,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_q_enable,
    output logic              o_q_rw,
    output logic [DATA_W-1:0] o_q_data_in,
    input  logic [DATA_W-1:0] i_q_data_out,
    input  logic              i_q_empty,
    input  logic              i_q_full,
    output logic              o_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StSettle, StDone} state_t;

    localparam logic [1:0] GntW0 = 2'd0;
    localparam logic [1:0] GntW1 = 2'd1;
    localparam logic [1:0] GntR  = 2'd2;

    state_t            r_state, w_state_d;
    logic [1:0]        r_grant, w_grant_d;
    logic              r_q_enable, w_q_enable_d;
    logic              r_q_rw, w_q_rw_d;
    logic [DATA_W-1:0] r_q_data_in, w_q_data_in_d;
    logic [DATA_W-1:0] r_rd_data, w_rd_data_d;
    logic              r_wr_ack0, w_wr_ack0_d;
    logic              r_wr_ack1, w_wr_ack1_d;
    logic              r_rd_valid, w_rd_valid_d;

    logic [2:0]        w_elig;
    logic              w_any;
    logic [1:0]        w_sel;

    // Both flags high is an impossible Queue state; treat it as nothing eligible.
    assign w_elig = (i_q_full && i_q_empty) ? 3'b000 :
                    {i_rd_req && !i_q_empty, i_wr_req1 && !i_q_full, i_wr_req0 && !i_q_full};
    assign w_any  = |w_elig;

`ifdef QUEUE_ARB_FIXED_PRIO_EN
    always_comb begin
        if (w_elig[0]) begin
            w_sel = GntW0;
        end else if (w_elig[1]) begin
            w_sel = GntW1;
        end else begin
            w_sel = GntR;
        end
    end
`else
    logic [1:0] r_rr_ptr, w_rr_ptr_d;

    function automatic logic [1:0] f_first(input logic [2:0] elig, input logic [1:0] a,
                                           input logic [1:0] b, input logic [1:0] c);
        if (elig[a]) begin
            return a;
        end else if (elig[b]) begin
            return b;
        end
        return c;
    endfunction

    always_comb begin
        case (r_rr_ptr)
            GntW1:   w_sel = f_first(w_elig, GntW1, GntR, GntW0);
            GntR:    w_sel = f_first(w_elig, GntR, GntW0, GntW1);
            default: w_sel = f_first(w_elig, GntW0, GntW1, GntR);
        endcase
    end

    // Pointer advances to the requester after the one just served.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr;
        if (r_state == StDone) begin
            case (r_grant)
                GntW0:   w_rr_ptr_d = GntW1;
                GntW1:   w_rr_ptr_d = GntR;
                default: w_rr_ptr_d = GntW0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rr_ptr <= GntW0;
        end else begin
            r_rr_ptr <= w_rr_ptr_d;
        end
    end
`endif

    always_comb begin
        w_state_d     = r_state;
        w_grant_d     = r_grant;
        w_q_enable_d  = 1'b0;
        w_q_rw_d      = 1'b0;
        w_q_data_in_d = r_q_data_in;
        w_rd_data_d   = r_rd_data;
        w_wr_ack0_d   = 1'b0;
        w_wr_ack1_d   = 1'b0;
        w_rd_valid_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_d    = StIssue;
                    w_grant_d    = w_sel;
                    w_q_enable_d = 1'b1;
                    w_q_rw_d     = (w_sel != GntR);
                    if (w_sel == GntW0) begin
                        w_q_data_in_d = i_wr_data0;
                    end else if (w_sel == GntW1) begin
                        w_q_data_in_d = i_wr_data1;
                    end
                end
            end
            StIssue:  w_state_d = StSettle;
            StSettle: w_state_d = StDone;
            StDone: begin
                w_state_d = StIdle;
                case (r_grant)
                    GntW0:   w_wr_ack0_d = 1'b1;
                    GntW1:   w_wr_ack1_d = 1'b1;
                    default: begin
                        w_rd_valid_d = 1'b1;
                        w_rd_data_d  = i_q_data_out;
                    end
                endcase
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_grant     <= GntW0;
            r_q_enable  <= 1'b0;
            r_q_rw      <= 1'b0;
            r_q_data_in <= '0;
            r_rd_data   <= '0;
            r_wr_ack0   <= 1'b0;
            r_wr_ack1   <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_grant     <= w_grant_d;
            r_q_enable  <= w_q_enable_d;
            r_q_rw      <= w_q_rw_d;
            r_q_data_in <= w_q_data_in_d;
            r_rd_data   <= w_rd_data_d;
            r_wr_ack0   <= w_wr_ack0_d;
            r_wr_ack1   <= w_wr_ack1_d;
            r_rd_valid  <= w_rd_valid_d;
        end
    end

    assign o_q_enable  = r_q_enable;
    assign o_q_rw      = r_q_rw;
    assign o_q_data_in = r_q_data_in;
    assign o_rd_data   = r_rd_data;
    assign o_wr_ack0   = r_wr_ack0;
    assign o_wr_ack1   = r_wr_ack1;
    assign o_rd_valid  = r_rd_valid;
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_queue_access_arbiter.sv
// Bench for queue_access_arbiter: 8-deep Queue stand-in plus an abstract arbitration model.
// Honours QUEUE_ARB_FIXED_PRIO_EN to match the DUT build.
module tb_queue_access_arbiter;
    localparam int DATA_W = 10;
    localparam int QDEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0;
    logic [DATA_W-1:0] wr_data0 = '0, wr_data1 = '0;
    logic              wr_ack0, wr_ack1, rd_valid, q_enable, q_rw, busy;
    logic [DATA_W-1:0] rd_data, q_data_in;
    logic              q_empty, q_full;
    logic              force_both = 1'b0;

    logic [DATA_W-1:0] env_mem[$];
    int                env_cnt = 0;
    logic [DATA_W-1:0] env_dout = '0;

    int                n_checks = 0;
    int                n_fail = 0;

    logic [DATA_W-1:0] m_q[$];
    int                m_ptr = 0;
    logic [DATA_W-1:0] m_din = '0;
    logic [DATA_W-1:0] m_rd = '0;
    bit                hold_all = 1'b0;
    bit                early_drop = 1'b0;

    queue_access_arbiter #(.DATA_W(DATA_W)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wr_req0    (wr_req0),
        .i_wr_data0   (wr_data0),
        .o_wr_ack0    (wr_ack0),
        .i_wr_req1    (wr_req1),
        .i_wr_data1   (wr_data1),
        .o_wr_ack1    (wr_ack1),
        .i_rd_req     (rd_req),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_q_enable   (q_enable),
        .o_q_rw       (q_rw),
        .o_q_data_in  (q_data_in),
        .i_q_data_out (env_dout),
        .i_q_empty    (q_empty),
        .i_q_full     (q_full),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Queue stand-in: samples the op on the clock edge while Enable is high.
    assign q_full  = (env_cnt == QDEPTH) || force_both;
    assign q_empty = (env_cnt == 0) || force_both;

    always @(posedge clk) begin
        if (q_enable) begin
            if (q_rw) begin
                if (env_cnt < QDEPTH) begin
                    env_mem.push_back(q_data_in);
                    env_cnt <= env_cnt + 1;
                end
            end else if (env_cnt > 0) begin
                env_dout <= env_mem.pop_front();
                env_cnt  <= env_cnt - 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ring order W0(0) -> W1(1) -> R(2); first eligible at or after the pointer wins.
    function automatic int m_pick();
        bit [2:0] el;
        bit       full, empty;
        int       start;
        full  = (m_q.size() == QDEPTH) || force_both;
        empty = (m_q.size() == 0) || force_both;
        el[0] = wr_req0 && !full;
        el[1] = wr_req1 && !full;
        el[2] = rd_req && !empty;
`ifdef QUEUE_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < 3; k++) begin
            if (el[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    task automatic drop(input int g);
        if (g == 0) wr_req0 = 1'b0;
        else if (g == 1) wr_req1 = 1'b0;
        else rd_req = 1'b0;
    endtask

    // One arbitration slot starting in IDLE: either nothing happens for a cycle, or a full op.
    task automatic run_slot();
        int         g;
        logic [2:0] exp_v;
        g = m_pick();
        tick();
        if (g < 0) begin
            chk("idle_en", 32'(q_enable), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_acks", 32'({wr_ack0, wr_ack1, rd_valid}), 0);
            return;
        end
        if (g == 0) m_din = wr_data0;
        else if (g == 1) m_din = wr_data1;
        chk("issue_en", 32'(q_enable), 1);
        chk("issue_busy", 32'(busy), 1);
        chk("issue_rw", 32'(q_rw), (g != 2) ? 1 : 0);
        chk("issue_din", 32'(q_data_in), 32'(m_din));
        if (early_drop) drop(g);
        tick();
        chk("settle_en", 32'(q_enable), 0);
        chk("settle_rw", 32'(q_rw), 0);
        tick();
        chk("done_acks", 32'({wr_ack0, wr_ack1, rd_valid}), 0);
        tick();
        if (g == 2) m_rd = m_q.pop_front();
        else m_q.push_back(m_din);
        exp_v = (g == 0) ? 3'b100 : (g == 1) ? 3'b010 : 3'b001;
        chk("ack_vec", 32'({wr_ack0, wr_ack1, rd_valid}), 32'(exp_v));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("ack_busy", 32'(busy), 0);
        m_ptr = (g + 1) % 3;
        if (!hold_all) drop(g);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_din = '0;
        m_rd  = '0;
    endtask

    task automatic drain();
        wr_req0 = 1'b0;
        wr_req1 = 1'b0;
        for (int i = 0; i < 12 && m_q.size() > 0; i++) begin
            rd_req = 1'b1;
            run_slot();
        end
        rd_req = 1'b0;
        chk("drained", 32'(m_q.size()), 0);
    endtask

    initial begin
        // Reset values, then reset asserted in the middle of a W0 ISSUE cycle.
        tick();
        tick();
        chk("rst_en", 32'(q_enable), 0);
        chk("rst_rw", 32'(q_rw), 0);
        chk("rst_din", 32'(q_data_in), 0);
        chk("rst_rd", 32'(rd_data), 0);
        chk("rst_acks", 32'({wr_ack0, wr_ack1, rd_valid}), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        model_reset();
        wr_req0 = 1'b1;
        wr_data0 = 10'd5;
        tick();
        chk("pre_rst_en", 32'(q_enable), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_en", 32'(q_enable), 0);
        chk("midrst_rw", 32'(q_rw), 0);
        chk("midrst_din", 32'(q_data_in), 0);
        chk("midrst_busy", 32'(busy), 0);
        wr_req0 = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abandon_ack", 32'({wr_ack0, q_enable, busy}), 0);
        end

        // Single write of 15, then read it back.
        wr_req0 = 1'b1;
        wr_data0 = 10'd15;
        run_slot();
        rd_req = 1'b1;
        run_slot();
        chk("rd15", 32'(rd_data), 15);

        // Both writers held from reset: W0 then W1, readback 17 then 20.
        rst = 1'b1;
        wr_req0 = 1'b1;
        wr_data0 = 10'd17;
        wr_req1 = 1'b1;
        wr_data1 = 10'd20;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rrst_rd", 32'(rd_data), 0);
        run_slot();
        run_slot();
        rd_req = 1'b1;
        run_slot();
        chk("rd17", 32'(rd_data), 17);
        rd_req = 1'b1;
        early_drop = 1'b1;
        run_slot();
        early_drop = 1'b0;
        chk("rd20", 32'(rd_data), 20);

        // Read on an empty queue is never served.
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) run_slot();
        rd_req = 1'b0;

        // Fill to full, blocked writer, read frees a slot, writer then completes.
        for (int i = 0; i < QDEPTH; i++) begin
            wr_req0 = 1'b1;
            wr_data0 = DATA_W'(100 + i);
            run_slot();
        end
        chk("full_flag", 32'(q_full), 1);
        wr_req1 = 1'b1;
        wr_data1 = 10'd333;
        for (int i = 0; i < 6; i++) run_slot();
        rd_req = 1'b1;
        run_slot();
        chk("full_rd", 32'(rd_data), 100);
        run_slot();
        chk("w1_after_full", 32'(m_q[QDEPTH-1]), 333);
        drain();

        // Both flags high: nothing eligible.
        wr_req0 = 1'b1;
        wr_data0 = 10'd7;
        force_both = 1'b1;
        for (int i = 0; i < 4; i++) run_slot();
        force_both = 1'b0;
        wr_req0 = 1'b0;

        // All three held continuously.
        hold_all = 1'b1;
        wr_req0 = 1'b1;
        wr_data0 = 10'd1;
        wr_req1 = 1'b1;
        wr_data1 = 10'd2;
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) run_slot();
        hold_all = 1'b0;
        drain();

        // Randomised traffic; requesters hold until served.
        for (int i = 0; i < 60; i++) begin
            if (!wr_req0 && $urandom_range(1, 0) == 1) begin
                wr_req0 = 1'b1;
                wr_data0 = DATA_W'($urandom);
            end
            if (!wr_req1 && $urandom_range(1, 0) == 1) begin
                wr_req1 = 1'b1;
                wr_data1 = DATA_W'($urandom);
            end
            if (!rd_req && $urandom_range(2, 0) != 0) rd_req = 1'b1;
            run_slot();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
